pal_gen2: RTL and testbench
===========================

PAL_GEN2 -- requirements
Module: pal_gen2

Interface
REQ-001 SHALL have parameter N, default 8, number of logic inputs.
REQ-002 SHALL have parameter P, default 8, number of product terms.
REQ-003 SHALL have parameter M, default 8, number of outputs / macrocells.
REQ-004 SHALL derive localparam L = 2*N*P + M*P + 2*M (config chain length; 208 at defaults).
REQ-005 SHALL have one clock and a synchronous, active-high reset: CLK  input  1  rising-edge clock; RES  input  1  synchronous active-high reset.
REQ-006 SHALL have CFG_EN  input  1  shift-enable for serial config.
REQ-007 SHALL have CFG_DATA  input  1  serial config bit.
REQ-008 SHALL have CFG_COMMIT  input  1  single-cycle pulse, copies shadow chain into active config.
REQ-009 SHALL have INPUT_VARS  input  N  logic inputs.
REQ-010 SHALL have OUTPUT_VALS  output  M  macrocell outputs.
REQ-011 SHALL have CFG_DOUT  output  1  bit shifted out of shadow chain (daisy-chain/readback).
REQ-012 SHALL have CFG_READY  output  1  high when exactly L bits shifted since last commit/reset.
REQ-013 SHALL have CFG_ERR  output  1  sticky, commit attempted with bit count != L.

Function
REQ-014 Shadow chain SHALL be an L-bit register; on CFG_EN=1 (and CFG_COMMIT=0) it shifts toward index 0, CFG_DATA enters index L-1, old index 0 appears on CFG_DOUT (registered, one-cycle delay).
REQ-015 After L shifts, the first bit shifted SHALL sit at index 0.
REQ-016 Bit map SHALL be: AND plane index p*2N+k (k<N: true INPUT_VARS[k]; k>=N: complement of INPUT_VARS[k-N]); OR plane base A=2NP, index A+m*P+p; macrocell base B=A+M*P, B+2m = registered-select, B+2m+1 = invert.
REQ-017 Product term p SHALL be the AND of selected literals; a term with no literal selected SHALL evaluate 0.
REQ-018 Sum m SHALL be OR of selected product terms, XOR invert bit m.
REQ-019 Macrocell m with registered-select=0 SHALL drive sum m combinationally (same-cycle response to INPUT_VARS).
REQ-020 Macrocell m with registered-select=1 SHALL drive a flop loaded with sum m every rising CLK edge (one-cycle latency).
REQ-021 Bit counter SHALL count CFG_EN shifts, saturating at L+1; CFG_READY = (count == L).
REQ-022 On CFG_COMMIT with count == L: active config <= shadow chain, CFG_ERR cleared; new config effective from the cycle after the commit edge.
REQ-023 On CFG_COMMIT with count != L: active config unchanged, CFG_ERR <= 1.
REQ-024 Any CFG_COMMIT SHALL clear the counter to 0; shadow chain contents SHALL be retained.
REQ-025 CFG_COMMIT and CFG_EN in the same cycle: commit evaluated on pre-edge count, shift ignored that cycle.
REQ-026 Shifting SHALL NOT alter active config or outputs (no glitch during load).
REQ-027 Registered macrocell flops SHALL keep their value across a commit and update from new config at the following edge.

Reset
REQ-028 On RES=1 at a CLK edge: shadow chain, active config, macrocell flops, counter, CFG_DOUT, CFG_ERR SHALL be 0.
REQ-029 After reset, OUTPUT_VALS SHALL be all-zero for any INPUT_VARS (all terms empty, all outputs combinational non-inverted).
REQ-030 RES SHALL override CFG_EN and CFG_COMMIT; a reset mid-shift discards the partial load.

Verification
REQ-031 Reset, INPUT_VARS sweep 0x00..0xFF -> OUTPUT_VALS = 0x00, CFG_READY=0, CFG_ERR=0.
REQ-032 Shift 208 bits (term0 = in0 AND NOT in1, out0 OR-selects term0, combinational), commit -> CFG_READY=1 before commit, 0 after; INPUT_VARS=0x01 gives OUTPUT_VALS=0x01, 0x03 gives 0x00 same cycle.
REQ-033 Same config with out0 registered-select=1 and invert=1 -> INPUT_VARS=0x01 gives OUTPUT_VALS[0]=0 one edge later, 0x00 gives 1 one edge later.
REQ-034 Shift 207 bits then commit -> CFG_ERR=1, outputs unchanged; reshift 208, commit -> CFG_ERR=0, new config active.
REQ-035 Shift 210 bits -> count saturates at 209, CFG_READY=0; CFG_DOUT replays first two bits shifted; commit -> CFG_ERR=1.
REQ-036 Assert RES after 100 shifts, then 208-bit load -> commit succeeds, no stale bits in active config.

Source files
------------

// File: rtl/pal_gen2.sv
`default_nettype none
// ============================================================================
// Module   : pal_gen2
// Purpose  : Serially configured PAL. Its AND/OR planes and its macrocells are
//            loaded through a shadow shift chain and then committed to the
//            active configuration in one step.
// Revision : 1.0  initial release
// ============================================================================
module pal_gen2 #(
  parameter int N = 8,
  parameter int P = 8,
  parameter int M = 8
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         CFG_EN,
  input  logic         CFG_DATA,
  input  logic         CFG_COMMIT,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS,
  output logic         CFG_DOUT,
  output logic         CFG_READY,
  output logic         CFG_ERR
);

  localparam int L  = 2*N*P + M*P + 2*M;
  localparam int A  = 2*N*P;
  localparam int B  = A + M*P;
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  logic [L-1:0]  shadow;
  logic [L-1:0]  active;
  logic [CW-1:0] bit_cnt;
  logic          dout_q;
  logic          err_q;
  logic [M-1:0]  mc_q;

  logic [2*N-1:0] literals;
  logic [P-1:0]   terms;
  logic [M-1:0]   sums;
  logic [M-1:0]   reg_sel;

  // Literal vector matches the AND-plane column order: true inputs first,
  // followed by their complements.
  assign literals = {~INPUT_VARS, INPUT_VARS};

  // Each product term ANDs its selected literals. A term with no literal
  // selected is forced to 0.
  for (genvar p = 0; p < P; p++) begin : g_term
    logic [2*N-1:0] sel;
    assign sel      = active[p*2*N +: 2*N];
    assign terms[p] = (&(literals | ~sel)) & (|sel);
  end

  // Each sum ORs its selected product terms and then applies its invert bit.
  for (genvar m = 0; m < M; m++) begin : g_sum
    logic [P-1:0] or_sel;
    assign or_sel     = active[A + m*P +: P];
    assign sums[m]    = (|(or_sel & terms)) ^ active[B + 2*m + 1];
    assign reg_sel[m] = active[B + 2*m];
  end

  // Config path: shadow shift, bit counter, commit and sticky error.
  // A commit takes priority over a shift that arrives in the same cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      shadow  <= '0;
      active  <= '0;
      bit_cnt <= '0;
      dout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (CFG_COMMIT) begin
      bit_cnt <= '0;
      if (bit_cnt == CNT_FULL) begin
        active <= shadow;
        err_q  <= 1'b0;
      end else begin
        err_q  <= 1'b1;
      end
    end else if (CFG_EN) begin
      shadow <= {CFG_DATA, shadow[L-1:1]};
      dout_q <= shadow[0];
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Macrocell flops capture their sum on every edge. They are not cleared
  // by a commit.
  always_ff @(posedge CLK) begin
    if (RES) begin
      mc_q <= '0;
    end else begin
      mc_q <= sums;
    end
  end

  assign OUTPUT_VALS = (reg_sel & mc_q) | (~reg_sel & sums);
  assign CFG_DOUT    = dout_q;
  assign CFG_READY   = (bit_cnt == CNT_FULL);
  assign CFG_ERR     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pal_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_pal_gen2
// Purpose  : Self-checking bench for pal_gen2 using directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_pal_gen2;

  localparam int N = 8;
  localparam int P = 8;
  localparam int M = 8;
  localparam int L = 208;
  localparam int A = 128;
  localparam int B = 192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_en = 1'b0;
  logic         cfg_data = 1'b0;
  logic         cfg_commit = 1'b0;
  logic [N-1:0] in_vars = '0;
  logic [M-1:0] out_vals;
  logic         cfg_dout;
  logic         cfg_ready;
  logic         cfg_err;

  int compared = 0;
  int mismatched = 0;

  pal_gen2 #(.N(N), .P(P), .M(M)) dut (
    .CLK        (clk),
    .RES        (rst),
    .CFG_EN     (cfg_en),
    .CFG_DATA   (cfg_data),
    .CFG_COMMIT (cfg_commit),
    .INPUT_VARS (in_vars),
    .OUTPUT_VALS(out_vals),
    .CFG_DOUT   (cfg_dout),
    .CFG_READY  (cfg_ready),
    .CFG_ERR    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cfg_id;
    logic [7:0] in;
    logic [7:0] exp;
  } vec_t;

  logic [L-1:0] cfg_a, cfg_b, cfg_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [L-1:0] cfg, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cfg_en   = 1'b1;
      cfg_data = cfg[i];
      tick();
    end
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic run_vectors(input int id, input vec_t vt[$]);
    foreach (vt[i]) begin
      if (vt[i].cfg_id == id) begin
        in_vars = vt[i].in;
        #1;
        chk($sformatf("cfg%0d_in%02h", id, vt[i].in), {24'd0, out_vals}, {24'd0, vt[i].exp});
      end
    end
  endtask

  initial begin
    vec_t vecs[$];

    // A: term0 = in0 & ~in1, out0 ORs term0 combinationally.
    cfg_a = '0;
    cfg_a[0]       = 1'b1;
    cfg_a[N + 1]   = 1'b1;
    cfg_a[A]       = 1'b1;
    // B: A with out0 registered and inverted.
    cfg_b = cfg_a;
    cfg_b[B]       = 1'b1;
    cfg_b[B + 1]   = 1'b1;
    // C: term1 = in7 drives out1; out2 is a constant 1 (empty sum inverted).
    cfg_c = '0;
    cfg_c[1*2*N + 7] = 1'b1;
    cfg_c[A + 1*P + 1] = 1'b1;
    cfg_c[B + 5]     = 1'b1;

    vecs.push_back('{1, 8'h01, 8'h01});
    vecs.push_back('{1, 8'h03, 8'h00});
    vecs.push_back('{1, 8'h00, 8'h00});
    vecs.push_back('{1, 8'h05, 8'h01});
    vecs.push_back('{1, 8'hFE, 8'h00});
    vecs.push_back('{1, 8'hFD, 8'h01});
    vecs.push_back('{3, 8'h00, 8'h04});
    vecs.push_back('{3, 8'h80, 8'h06});
    vecs.push_back('{3, 8'h7F, 8'h04});
    vecs.push_back('{3, 8'hFF, 8'h06});

    // Reset state and all-zero outputs for every input pattern.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_err",   {31'd0, cfg_err},   32'd0);
    chk("rst_dout",  {31'd0, cfg_dout},  32'd0);
    for (int v = 0; v < 256; v++) begin
      in_vars = 8'(v);
      #1;
      chk("rst_sweep", {24'd0, out_vals}, 32'd0);
    end

    // Full load of A, then commit.
    shift_bits(cfg_a, L);
    chk("a_ready_pre", {31'd0, cfg_ready}, 32'd1);
    in_vars = 8'h01;
    #1;
    chk("a_no_effect_pre_commit", {24'd0, out_vals}, 32'd0);
    commit();
    chk("a_ready_post", {31'd0, cfg_ready}, 32'd0);
    chk("a_err_post",   {31'd0, cfg_err},   32'd0);
    run_vectors(1, vecs);

    // B: registered and inverted out0.
    shift_bits(cfg_b, L);
    commit();
    in_vars = 8'h01;
    tick();
    chk("b_reg_in01", {31'd0, out_vals[0]}, 32'd0);
    in_vars = 8'h00;
    #1;
    chk("b_reg_hold", {31'd0, out_vals[0]}, 32'd0);
    tick();
    chk("b_reg_in00", {24'd0, out_vals}, 32'h01);

    // Short load: the commit is rejected and outputs are left unchanged.
    shift_bits(cfg_c, L - 1);
    chk("short_out_during_load", {24'd0, out_vals}, 32'h01);
    chk("short_ready", {31'd0, cfg_ready}, 32'd0);
    commit();
    chk("short_err", {31'd0, cfg_err}, 32'd1);
    tick();
    chk("short_out_unchanged", {24'd0, out_vals}, 32'h01);
    shift_bits(cfg_c, L);
    commit();
    chk("c_err_cleared", {31'd0, cfg_err}, 32'd0);
    run_vectors(3, vecs);

    // Overlong load: the counter saturates and DOUT replays the first bits.
    shift_bits(cfg_a, L);
    cfg_en = 1'b1; cfg_data = 1'b0;
    tick();
    chk("sat_dout_first", {31'd0, cfg_dout}, {31'd0, cfg_a[0]});
    chk("sat_ready_209", {31'd0, cfg_ready}, 32'd0);
    tick();
    cfg_en = 1'b0;
    chk("sat_dout_second", {31'd0, cfg_dout}, {31'd0, cfg_a[1]});
    chk("sat_ready_210", {31'd0, cfg_ready}, 32'd0);
    commit();
    chk("sat_err", {31'd0, cfg_err}, 32'd1);
    in_vars = 8'h80;
    #1;
    chk("sat_cfg_kept", {24'd0, out_vals}, 32'h06);

    // Commit together with a shift: the shift is dropped and the count restarts at 0.
    shift_bits(cfg_a, L);
    cfg_en = 1'b1; cfg_data = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0; cfg_data = 1'b0;
    chk("both_err", {31'd0, cfg_err}, 32'd0);
    chk("both_ready", {31'd0, cfg_ready}, 32'd0);
    run_vectors(1, vecs);
    shift_bits(cfg_c, L);
    chk("both_ready_after_reload", {31'd0, cfg_ready}, 32'd1);
    commit();
    chk("both_err_reload", {31'd0, cfg_err}, 32'd0);
    run_vectors(3, vecs);

    // Reset in the middle of a load discards the partial bits.
    shift_bits({L{1'b1}}, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_vars = 8'h80;
    #1;
    chk("midrst_out", {24'd0, out_vals}, 32'd0);
    chk("midrst_dout", {31'd0, cfg_dout}, 32'd0);
    shift_bits(cfg_a, L);
    chk("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    commit();
    chk("midrst_err", {31'd0, cfg_err}, 32'd0);
    run_vectors(1, vecs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
